uart_tx: RTL

Serial UART transmitter that serialises bytes from an upstream producer, such as the message printer, onto the `tx` line. It uses a `busy`/`new_data` handshake: the producer pulses `new_data` only while `busy` is low. It sits between the message-generating logic and the top-level TX pin. An external flow-control `block` input lets the host side stall transmission.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_bit_timer.sv | 39 +++
 rtl/uart_tx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared state encoding, parity modes and parity helper for the
//            UART transmitter and receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Odd mode makes the total count of ones odd, even mode makes it even.
    function automatic logic parity_bit(input logic [7:0] b, input int mode);
        if (mode == PARITY_ODD) begin
            return ~^b;
        end
        return ^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// ============================================================================
// Module   : uart_bit_timer
// Purpose  : Free-running bit-period counter; pulses bit_done on the last
//            cycle of each bit period and holds at zero while run is low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bit_timer #(
    parameter int CLK_PER_BIT = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_done
);

    localparam int                c_cnt_w = $clog2(CLK_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLK_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_count;
    logic               w_wrap;

    assign w_wrap   = (r_count == c_last);
    assign bit_done = run && w_wrap;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            r_count <= '0;
        end else if (w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Purpose  : 8-bit UART transmitter with busy/new_data handshake, optional
//            parity, one or two stop bits and host flow control via block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 100,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic       tx,
    input  logic       block,
    output logic       busy,
    input  logic [7:0] data,
    input  logic       new_data
);

    generate
        if (CLK_PER_BIT < 2 || PARITY < 0 || PARITY > 2 ||
            (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
            $error("uart_tx: illegal parameter combination");
        end
    endgenerate

    localparam logic c_last_stop = 1'(STOP_BITS - 1);

    uart_state_t r_state;
    uart_state_t w_state_next;
    logic [7:0]  r_data;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_next;
    logic        r_stop_idx;
    logic        w_stop_idx_next;
    logic        r_tx;
    logic        r_busy;
    logic        w_tx_next;
    logic        w_busy_next;
    logic        w_accept;
    logic        w_bit_done;
    logic        w_timer_run;
    logic        w_parity;

    assign tx          = r_tx;
    assign busy        = r_busy;
    assign w_accept    = (r_state == ST_IDLE) && !r_busy && new_data;
    assign w_timer_run = (r_state != ST_IDLE);
    assign w_parity    = parity_bit(r_data, PARITY);

    uart_bit_timer #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .run      (w_timer_run),
        .bit_done (w_bit_done)
    );

    always_comb begin
        w_state_next    = r_state;
        w_bit_idx_next  = r_bit_idx;
        w_stop_idx_next = r_stop_idx;
        w_tx_next       = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next    = ST_START;
                    w_bit_idx_next  = 3'd0;
                    w_stop_idx_next = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_next    = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        w_stop_idx_next = 1'b0;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_done) begin
                    w_state_next    = ST_STOP;
                    w_stop_idx_next = 1'b0;
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    if (r_stop_idx == c_last_stop) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_stop_idx_next = r_stop_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Line level is derived from the upcoming state so tx is a clean flop.
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = r_data[w_bit_idx_next];
            ST_PARITY: w_tx_next = w_parity;
            default:   w_tx_next = 1'b1;
        endcase
    end

    assign w_busy_next = (w_state_next != ST_IDLE) || block;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bit_idx  <= 3'd0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_bit_idx  <= w_bit_idx_next;
            r_stop_idx <= w_stop_idx_next;
            r_tx       <= w_tx_next;
            r_busy     <= w_busy_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data <= data;
        end
    end

endmodule

`default_nettype wire
